// File: rtl/regfile_pkg.sv
// Shared types, default sizes and index helpers for the multi-port register file
// and its dump engine.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } dump_state_t;

    // Next register index to dump; the PC alias holds no storage and is stepped over.
    function automatic int next_idx(input int cur, input int pc_idx);
        int nxt;
        nxt = cur + 1;
        if (nxt == pc_idx) begin
            nxt = nxt + 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/regfile_dump_fsm.sv
// Dump engine: walks the architectural registers one beat per valid/ready handshake,
// reading storage through an index/data pair owned by the register file.
module regfile_dump_fsm
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int PC_IDX = NREGS - 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dump_start_i,
    input  logic              dump_ready_i,
    output logic              dump_valid_o,
    output logic [AW-1:0]     dump_idx_o,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_done_o,
    output logic [AW-1:0]     rd_idx_o,
    input  logic [DATA_W-1:0] rd_data_i
);

    // First and last indices that actually hold storage (the PC alias may sit at either end).
    localparam int FIRST_IDX = (PC_IDX == 0) ? 1 : 0;
    localparam int LAST_IDX  = (PC_IDX == NREGS - 1) ? NREGS - 2 : NREGS - 1;

    dump_state_t   state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (dump_start_i) begin
                    state_d = SCAN;
                    cnt_d   = AW'(FIRST_IDX);
                end
            end
            SCAN: begin
                if (dump_ready_i) begin
                    if (cnt_q == AW'(LAST_IDX)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = AW'(next_idx(int'(cnt_q), PC_IDX));
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Data is read live from storage so a register written before its beat shows the new value.
    assign rd_idx_o     = cnt_q;
    assign dump_valid_o = (state_q == SCAN);
    assign dump_done_o  = (state_q == DONE);
    assign dump_idx_o   = cnt_q;
    assign dump_data_o  = rd_data_i;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational read ports, ALU and load write ports,
// a per-register busy scoreboard and a handshake-driven dump engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 3,
    parameter int PC_IDX = NREGS - 1,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            we,
    input  logic [2*AW-1:0]       wa,
    input  logic [2*DATA_W-1:0]   wd,
    input  logic [NRD*AW-1:0]     ra,
    input  logic [DATA_W-1:0]     pc_in,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_idx,
    output logic [NREGS-1:0]      busy,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [AW-1:0]         dump_idx,
    output logic [DATA_W-1:0]     dump_data,
    output logic                  dump_done
);

    localparam logic [AW-1:0] PC_A = AW'(PC_IDX);

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;

    logic [AW-1:0]     wa_p [2];
    logic [DATA_W-1:0] wd_p [2];
    logic [1:0]        wr_en;

    logic [AW-1:0]     dump_rd_idx;
    logic [DATA_W-1:0] dump_rd_data;

    genvar gi;

    // Unpack write ports; a write aimed at the PC alias is discarded here.
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wport
            assign wa_p[gi]  = wa[gi*AW +: AW];
            assign wd_p[gi]  = wd[gi*DATA_W +: DATA_W];
            assign wr_en[gi] = we[gi] && (wa_p[gi] != PC_A);
        end
    endgenerate

    // Port 1 is applied last so the load result wins an address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (wr_en[0]) begin
                rf_q[wa_p[0]] <= wd_p[0];
            end
            if (wr_en[1]) begin
                rf_q[wa_p[1]] <= wd_p[1];
            end
        end
    end

    // Scoreboard: writeback clears, issue sets, and issue wins on a same-cycle tie.
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            logic clr_b;
            logic set_b;
            assign clr_b = (wr_en[0] && (wa_p[0] == AW'(gi))) ||
                           (wr_en[1] && (wa_p[1] == AW'(gi)));
            assign set_b = iss_en && (iss_idx == AW'(gi)) && (iss_idx != PC_A);
            assign busy_d[gi] = (busy_q[gi] && !clr_b) || set_b;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rport
            logic [AW-1:0]     ra_g;
            logic [DATA_W-1:0] val;
            logic              bsy;

            assign ra_g = ra[gi*AW +: AW];

            always_comb begin
                val = rf_q[ra_g];
                bsy = busy_q[ra_g];
                if (BYPASS != 0) begin
                    if (wr_en[0] && (wa_p[0] == ra_g)) begin
                        val = wd_p[0];
                    end
                    if (wr_en[1] && (wa_p[1] == ra_g)) begin
                        val = wd_p[1];
                    end
                end
                if (ra_g == PC_A) begin
                    val = pc_in;
                    bsy = 1'b0;
                end
            end

            assign rd[gi*DATA_W +: DATA_W] = val;
            assign rd_busy[gi]             = bsy;
        end
    endgenerate

    // The dump sees stored contents only, never same-cycle bypass data.
    assign dump_rd_data = rf_q[dump_rd_idx];

    regfile_dump_fsm #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .PC_IDX (PC_IDX)
    ) u_dump (
        .clk          (clk),
        .reset        (reset),
        .dump_start_i (dump_start),
        .dump_ready_i (dump_ready),
        .dump_valid_o (dump_valid),
        .dump_idx_o   (dump_idx),
        .dump_data_o  (dump_data),
        .dump_done_o  (dump_done),
        .rd_idx_o     (dump_rd_idx),
        .rd_data_i    (dump_rd_data)
    );

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the datapath: NREGS × DATA_W storage, NRD combinational read ports, two write ports (ALU result, load writeback) and a per-register busy scoreboard for in-flight producers. It includes a synthesizable dump engine that streams the architectural registers one per handshake, replacing simulation-only printing. The PC index is never stored; reads of it return the externally supplied PC value.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NREGS, 16, number of architectural registers; power of two, ≥4
- NRD, 3, number of read ports
- PC_IDX, NREGS-1, index aliased to the external PC input
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns stored data

Ports (AW = $clog2(NREGS)):
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- we  in  2  write enables; bit 0 = ALU port, bit 1 = load port
- wa  in  2*AW  write addresses, port p at [p*AW +: AW]
- wd  in  2*DATA_W  write data, port p at [p*DATA_W +: DATA_W]
- ra  in  NRD*AW  read addresses, packed the same way
- pc_in  in  DATA_W  value returned for reads of PC_IDX
- rd  out  NRD*DATA_W  read data
- rd_busy  out  NRD  busy flag of the addressed register, per read port
- iss_en  in  1  mark register iss_idx busy
- iss_idx  in  AW  register being claimed by an issued producer
- busy  out  NREGS  full scoreboard vector
- dump_start  in  1  start a dump (honoured only in IDLE)
- dump_ready  in  1  consumer accepts the current dump beat
- dump_valid  out  1  dump beat valid
- dump_idx  out  AW  register index of the current beat
- dump_data  out  DATA_W  register contents of the current beat
- dump_done  out  1  single-cycle pulse after the last beat is accepted

## Operation
- Writes: rf[wa[p]] <= wd[p] when we[p] and wa[p] != PC_IDX. Writes to PC_IDX are dropped silently.
- Both ports write the same address in one cycle: the load port (bit 1) wins.
- Reads are combinational. For ra == PC_IDX, rd = pc_in and rd_busy = 0.
- Otherwise, with BYPASS=1, a read matching an enabled write port returns that port's wd, using the same priority rule. With BYPASS=0, a read returns rf.
- Scoreboard:
  - An enabled write to index i clears busy[i].
  - iss_en sets busy[iss_idx].
  - Set and clear on the same index in the same cycle: set wins.
  - iss_idx == PC_IDX is ignored.
  - rd_busy reflects registered busy, not same-cycle updates.
- Dump FSM states: IDLE, SCAN, DONE.
  - IDLE to SCAN on dump_start; the counter loads 0.
  - In SCAN: dump_valid = 1, dump_idx = counter, dump_data = rf[counter] (stored value, no bypass).
  - On dump_valid & dump_ready, the counter increments, skipping PC_IDX.
  - After the beat at the highest non-PC index is accepted, go to DONE.
  - DONE asserts dump_done for 1 cycle, then returns to IDLE.
  - dump_start outside IDLE is ignored.
  - Writes during a dump are legal; beats not yet sent show the updated values.

## Timing
- Reset values: all rf = 0, busy = 0, FSM = IDLE, dump_valid = 0, dump_done = 0, dump_idx = 0, dump_data = rf[0] = 0.
- Reset asserted mid-dump aborts it: no dump_done, state returns to IDLE.
- Reset has priority over every write and issue.
- Write latency: a stored value is visible to non-bypassed reads 1 cycle after the write edge.
- With BYPASS=1, the value is visible in the same cycle.
- Scoreboard updates are visible on busy/rd_busy the cycle after the edge.
- Dump:
  - The first beat is valid 1 cycle after dump_start is sampled.
  - With dump_ready held high, there are NREGS-1 beats on consecutive cycles.
  - dump_done follows the cycle after the last accepted beat.
- dump_valid stays high and dump_idx/dump_data stay stable until accepted. dump_data may change only if that register is written.

## Structure
- Package regfile_pkg:
  - typedef dump_state_t {IDLE, SCAN, DONE}
  - default constants DATA_W_DEF = 32, NREGS_DEF = 16
  - function next_idx(cur, pc_idx), which skips PC_IDX
- One sub-module, regfile_dump_fsm: FSM, counter, handshake. It takes an AW-bit read index out and a DATA_W read value back. Storage, bypass and scoreboard stay in regfile_mp.

## Test plan
- Reset, then write R3 = 0xDEADBEEF via port 0 → next cycle rd[0] for ra = 3 reads 0xDEADBEEF. A write to PC_IDX with pc_in = 0x100 leaves rd = 0x100 and stored contents unchanged.
- Same-cycle port0 R5 = 0x11 and port1 R5 = 0x22, with ra = 5 → BYPASS=1 gives rd = 0x22 in that cycle. For both BYPASS settings, stored R5 = 0x22 afterwards.
- iss_en on idx 7 → busy[7] = 1 next cycle. Write R7 with iss_en idx 7 in the same cycle → busy[7] stays 1. A later write to R7 alone → busy[7] = 0.
- Fill R0–R14 with 0x1000+i, pulse dump_start, hold dump_ready = 1 → 15 beats, idx 0..14, data 0x1000..0x100E, then a single dump_done pulse.
- Dump with dump_ready toggling 1-0-1 → each beat holds while ready is low, with no skipped or duplicated idx. A second dump_start mid-dump is ignored.
- Assert reset at beat 6 of a dump → dump_valid = 0 the next cycle, no dump_done, all rf = 0, busy = 0.
